// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and helpers.
package aes_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {IDLE, FWD, REV} ks_state_e;

  // Round constant in the top byte; rounds outside 1..10 give zero.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] b;
    case (r)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h0};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, pure lookup.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 sits in the top byte, so index with the inverted input.
  localparam logic [255:0][7:0] TBL = 2048'h
637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

  assign dout = TBL[~din];

endmodule

// File: rtl/inv_key_round.sv
// One reverse key-schedule step: round key r -> round key r-1.
module inv_key_round
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key,
  input  logic [3:0]           round,
  input  logic [31:0]          sub,   // SubWord(RotWord(w3 ^ w2)) from the shared unit
  output logic [AES_KEY_W-1:0] prev
);

  logic [31:0] w0, w1, w2, w3;

  assign {w0, w1, w2, w3} = key;

  // Undo the XOR chain first; only p0 needs the S-box result.
  assign prev = {w0 ^ sub ^ rcon(round), w1 ^ w0, w2 ^ w1, w3 ^ w2};

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 decryption key scheduler: expands forward, then
// streams round keys 10..0 over valid/ready.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter bit LOAD_LAST_KEY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] keyIn,
  output logic [AES_KEY_W-1:0] keyOut,
  output logic                 keyValid,
  input  logic                 keyReady,
  output logic [3:0]           roundIdx,
  output logic                 busy,
  output logic                 done
);

  ks_state_e            state, state_nxt;
  logic [AES_KEY_W-1:0] key_q, key_nxt, prev_key, fwd_key;
  logic [3:0]           round_q, round_nxt;
  logic                 done_q, done_nxt;
  logic [31:0]          w0, w1, w2, w3, p3, sub_in, sub_word, f0, f1, f2, f3;
  logic                 hs;

  assign {w0, w1, w2, w3} = key_q;
  assign p3 = w3 ^ w2;

  // Single SubWord unit shared by both directions.
  assign sub_in = (state == FWD) ? rot_word(w3) : rot_word(p3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.din(sub_in[8*i +: 8]), .dout(sub_word[8*i +: 8]));
  end

  // Forward expansion step toward round roundIdx+1.
  assign f0 = w0 ^ sub_word ^ rcon(round_q + 4'd1);
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  inv_key_round u_inv (
    .key   (key_q),
    .round (round_q),
    .sub   (sub_word),
    .prev  (prev_key)
  );

  assign keyValid = (state == REV);
  assign hs       = keyValid && keyReady;
  assign busy     = (state != IDLE);
  assign keyOut   = key_q;
  assign roundIdx = round_q;
  assign done     = done_q;

  // Next-state, key and round update.
  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    round_nxt = round_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt = keyIn;
          if (LOAD_LAST_KEY) begin
            round_nxt = 4'(AES_ROUNDS);
            state_nxt = REV;
          end else begin
            round_nxt = 4'd0;
            state_nxt = FWD;
          end
        end
      end
      FWD: begin
        key_nxt   = fwd_key;
        round_nxt = round_q + 4'd1;
        if (round_q == 4'(AES_ROUNDS - 1)) state_nxt = REV;
      end
      REV: begin
        if (hs) begin
          if (round_q != 4'd0) begin
            key_nxt   = prev_key;
            round_nxt = round_q - 4'd1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset abandons any sequence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      key_q   <= key_nxt;
      round_q <= round_nxt;
      done_q  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule in both load modes.
module tb_inv_key_schedule;

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_s [2];
  logic [127:0] keyin_s [2];
  logic [127:0] ko      [2];
  logic         vld     [2];
  logic         rdy     [2];
  logic [3:0]   ri      [2];
  logic         bz      [2];
  logic         dn      [2];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  // Edge counter used to place events in spec cycle numbers.
  always @(posedge clk) cyc <= cyc + 1;

  inv_key_schedule #(.LOAD_LAST_KEY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .keyIn(keyin_s[0]),
    .keyOut(ko[0]), .keyValid(vld[0]), .keyReady(rdy[0]), .roundIdx(ri[0]),
    .busy(bz[0]), .done(dn[0])
  );

  inv_key_schedule #(.LOAD_LAST_KEY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .keyIn(keyin_s[1]),
    .keyOut(ko[1]), .keyValid(vld[1]), .keyReady(rdy[1]), .roundIdx(ri[1]),
    .busy(bz[1]), .done(dn[1])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: textbook forward expansion with an S-box derived
  // from the GF(2^8) inverse and affine map.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] msbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_rk(input logic [127:0] ck, input int r);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {msbox(t[23:16]), msbox(t[15:8]), msbox(t[7:0]), msbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // One full sequence on DUT d, with optional stall, stray starts, or a
  // reset when roundIdx reaches 5.
  task automatic run(input int d, input logic [127:0] ck, input int stall,
                     input bit extra, input bit rst_mid);
    logic [127:0] rk[11];
    exp_t e;
    int   s0, c, first_v, done_c, stall_left;
    bit   aborted;
    for (int r = 0; r <= 10; r++) rk[r] = model_rk(ck, r);
    q.delete();
    for (int r = 10; r >= 0; r--) begin
      e.r = 4'(r);
      e.k = rk[r];
      q.push_back(e);
    end
    @(posedge clk);
    #1 start_s[d] = 1'b1;
    keyin_s[d] = (d == 1) ? rk[10] : ck;
    @(posedge clk);
    #1 s0 = cyc;
    start_s[d] = 1'b0;
    keyin_s[d] = '0;
    chk("busy_c1", 128'(bz[d]), 128'd1);
    first_v = -1;
    done_c = -1;
    stall_left = stall;
    aborted = 1'b0;
    for (int n = 0; n < 80 && done_c < 0 && !aborted; n++) begin
      @(negedge clk);
      c = cyc - s0 + 1;
      start_s[d] = extra && (c == 4 || c == 14);
      if (start_s[d]) keyin_s[d] = 128'hdeadbeef;
      if (vld[d] && first_v < 0) first_v = c;
      if (dn[d]) begin
        done_c = c;
        chk("busy_at_done", 128'(bz[d]), 128'd0);
      end
      if (rst_mid && vld[d] && ri[d] == 4'd5) begin
        rst_n = 1'b0;
        #1;
        chk("rst_keyOut", ko[d], 128'd0);
        chk("rst_valid", 128'(vld[d]), 128'd0);
        chk("rst_round", 128'(ri[d]), 128'd0);
        chk("rst_busy", 128'(bz[d]), 128'd0);
        chk("rst_done", 128'(dn[d]), 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("post_rst_idle", 128'({bz[d], vld[d], dn[d]}), 128'd0);
        end
        q.delete();
        aborted = 1'b1;
      end else begin
        if (vld[d] && ri[d] == 4'd9 && stall_left > 0) begin
          rdy[d] = 1'b0;
          stall_left--;
          chk("stall_key", ko[d], rk[9]);
          chk("stall_idx", 128'(ri[d]), 128'd9);
        end else begin
          rdy[d] = 1'b1;
        end
        if (vld[d] && rdy[d]) begin
          if (q.size() == 0) begin
            chk("extra_key", 128'(ri[d]), 128'hff);
          end else begin
            e = q.pop_front();
            chk("rk_key", ko[d], e.k);
            chk("rk_idx", 128'(ri[d]), 128'(e.r));
            if (ck == FIPS && e.r == 4'd10) chk("fips_k10", ko[d], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            if (ck == FIPS && e.r == 4'd9)  chk("fips_k9",  ko[d], 128'hac7766f319fadc2128d12941575c006e);
            if (ck == FIPS && e.r == 4'd1)  chk("fips_k1",  ko[d], 128'ha0fafe1788542cb123a339392a6c7605);
            if (ck == FIPS && e.r == 4'd0)  chk("fips_k0",  ko[d], FIPS);
            if (ck == '0 && e.r == 4'd10)   chk("zero_k10", ko[d], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
            if (ck == '0 && e.r == 4'd1)    chk("zero_k1",  ko[d], 128'h62636363626363636263636362636363);
            if (ck == '0 && e.r == 4'd0)    chk("zero_k0",  ko[d], 128'd0);
          end
        end
      end
    end
    start_s[d] = 1'b0;
    rdy[d] = 1'b1;
    if (!aborted) begin
      chk("first_valid_cycle", 128'(first_v), 128'((d == 1) ? 1 : 11));
      chk("done_cycle", 128'(done_c), 128'(((d == 1) ? 12 : 22) + stall));
      chk("queue_drained", 128'(q.size()), 128'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      keyin_s[i] = '0;
      rdy[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("reset_keyOut", ko[0], 128'd0);
    chk("reset_flags", 128'({vld[0], bz[0], dn[0], ri[0]}), 128'd0);
    chk("reset_flags_ll", 128'({vld[1], bz[1], dn[1], ri[1]}), 128'd0);
    rst_n = 1'b1;
    run(0, FIPS, 0, 1'b0, 1'b0);
    run(1, FIPS, 0, 1'b0, 1'b0);
    run(0, '0, 0, 1'b0, 1'b0);
    run(0, FIPS, 5, 1'b0, 1'b0);
    run(0, FIPS, 0, 1'b1, 1'b0);
    run(1, FIPS, 0, 1'b1, 1'b0);
    run(0, FIPS, 0, 1'b0, 1'b1);
    run(0, FIPS, 0, 1'b0, 1'b0);
    run(0, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Iterative AES-128 decryption key scheduler. It accepts a cipher key, expands it forward to the round-10 key, then streams the round keys in reverse order (round 10 down to round 0) over a valid/ready interface. Each reverse step computes the previous round key on the fly, so no 11×128 key store is needed. It sits between key load and the inverse-cipher round datapath, which consumes round keys last-first.

## Interface
- LOAD_LAST_KEY, default 0: 0 = keyIn is the cipher key (round 0); 1 = keyIn is already the round-10 key and the forward phase is skipped.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- keyIn  in  128  cipher key (or round-10 key when LOAD_LAST_KEY=1); word 0 is in [127:96].
- keyOut  out  128  current round key, registered.
- keyValid  out  1  keyOut/roundIdx hold a valid round key.
- keyReady  in  1  consumer accepts keyOut when keyValid && keyReady.
- roundIdx  out  4  round number of keyOut, 10 down to 0.
- busy  out  1  high in FWD and REV.
- done  out  1  one-cycle pulse after the round-0 key is accepted.

## Operation
- States: IDLE, FWD, REV.
- IDLE: if start is high, key register <= keyIn. roundIdx <= 0 and the next state is FWD when LOAD_LAST_KEY=0; roundIdx <= 10 and the next state is REV when LOAD_LAST_KEY=1.
- FWD: one forward expansion round per cycle: w0' = w0^SubWord(RotWord(w3))^Rcon(r+1), then w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'. roundIdx increments each cycle. After the step that writes roundIdx=10, go to REV.
- REV: keyValid = 1. On handshake with roundIdx>0, the key register <= the previous key and roundIdx decrements:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
  - p0 = w0^SubWord(RotWord(p3))^Rcon(roundIdx).
- REV, handshake with roundIdx=0: go to IDLE, pulse done, clear keyValid.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the top byte; all other round numbers give 0.
- One 4-byte SubWord unit is shared by the FWD and REV phases: a mux selects RotWord(w3) or RotWord(p3) by state.
- keyOut is the key register and is driven in every state. It is meaningful only while keyValid is high.
- While keyValid && !keyReady, keyOut and roundIdx hold stable.
- start is ignored while busy. It is not queued.
- Handshakes are counted only in REV. keyReady is a don't-care in other states.

## Timing
- Reset values: keyOut = 0, keyValid = 0, roundIdx = 0, busy = 0, done = 0, state IDLE.
- Reset is effective immediately, including mid-FWD or mid-REV. The sequence in progress is abandoned and nothing resumes after reset is released.
- start sampled high at edge 0, LOAD_LAST_KEY=0:
  - busy is high from cycle 1.
  - keyValid rises in cycle 11 with roundIdx=10.
  - With keyReady held high, keys 10..0 appear in cycles 11..21, one per cycle.
  - done pulses in cycle 22, and busy is low in cycle 22.
- LOAD_LAST_KEY=1: the first key is valid in cycle 1, the last in cycle 11, and done pulses in cycle 12.
- The earliest next start is accepted in the done cycle. The state is IDLE then.
- Each stalled cycle in REV adds exactly one cycle of latency.
- The reverse step is one combinational round (4 S-boxes plus XORs) feeding a register. No multicycle paths.

## Structure
- Shared package aes_pkg:
  - state enum (IDLE/FWD/REV);
  - Rcon lookup function indexed by 4-bit round number;
  - RotWord function;
  - AES_KEY_W = 128 and AES_ROUNDS = 10 constants.
- Sub-module inv_key_round (combinational): takes a round key, its round number and the SubWord result, and returns the previous round key.
- The forward step is inline.
- The SubWord unit is 4 instances of the existing SBox.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, LOAD_LAST_KEY=0, keyReady=1:
  - cycle 11: d014f9a8c9ee2589e13f0cc8b6630ca6, roundIdx=10;
  - cycle 12: ac7766f319fadc2128d12941575c006e;
  - cycle 20: a0fafe1788542cb123a339392a6c7605;
  - cycle 21: 2b7e1516…, roundIdx=0;
  - cycle 22: done=1.
- LOAD_LAST_KEY=1, keyIn d014f9a8c9ee2589e13f0cc8b6630ca6: valid in cycle 1, 2b7e151628aed2a6abf7158809cf4f3c in cycle 11, done in cycle 12.
- All-zero key:
  - key 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - key 1 = 62636363626363636263636362636363;
  - key 0 = 0.
- Backpressure: hold keyReady=0 for 5 cycles while roundIdx=9. keyOut stays ac7766f3… and roundIdx stays 9. Completion shifts by exactly 5 cycles.
- Pulse start again during FWD and during REV: ignored, and the output sequence is unchanged.
- Assert rst_n=0 mid-REV (roundIdx=5):
  - all outputs read 0 immediately;
  - after release, no activity until start;
  - a new start reproduces the FIPS-197 sequence.
